dram_resp: RTL and testbench

Synthesizable DRAM responder serving the accelerator's external memory port: `en_wr`/`addr_wr`/`data_in` for writes and `en_rd`/`addr_rd`, returning `valid`/`data_out`. It replaces the behavioural DRAM model in FPGA and emulation builds. It provides:
- an on-chip backing store;
- a fixed-latency, fully pipelined read path;
- periodic refresh windows that force the requester to honour `busy`.

---
 rtl/dram_resp_pkg.sv | 13 +
 rtl/dram_resp_rd_pipe.sv | 39 +++
 rtl/dram_resp.sv | 148 ++++++++++++++
 tb/tb_dram_resp.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_resp_pkg.sv
// Shared types and constants for the DRAM responder.
package dram_resp_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 18;
   localparam int RD_LATENCY_MAX = 16;

   typedef enum logic {
      ACTIVE  = 1'b0,
      REFRESH = 1'b1
   } state_t;

endpackage

// File: rtl/dram_resp_rd_pipe.sv
// Fixed-depth {valid, data} read-return shift register.
// Only the valid bits are reset; data words simply follow their valid bit.
module dram_resp_rd_pipe
   import dram_resp_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int STAGES     = 4
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  in_vld,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_vld,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [STAGES:1]       vld_pipe;
   logic [DATA_WIDTH-1:0] dat_pipe [1:STAGES];

   // valid bits shift every cycle; reset flushes in-flight reads
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[1] <= in_vld;
         for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
      end
   end

   // data words shift alongside their valid bits
   always_ff @(posedge clk) begin
      dat_pipe[1] <= in_data;
      for (int i = 2; i <= STAGES; i++) dat_pipe[i] <= dat_pipe[i-1];
   end

   assign out_vld  = vld_pipe[STAGES];
   assign out_data = dat_pipe[STAGES];

endmodule

// File: rtl/dram_resp.sv
// Synthesizable DRAM responder: on-chip store, fixed-latency pipelined reads,
// periodic refresh windows signalled on busy.
// Optional feature: define DRAM_RESP_STATS_EN to add rd_count/wr_count outputs.
module dram_resp
   import dram_resp_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int MEM_AW         = 12,
   parameter int RD_LATENCY     = 4,
   parameter int REFRESH_PERIOD = 1024,
   parameter int REFRESH_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  en_wr,
   input  logic [ADDR_WIDTH-1:0] addr_wr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  en_rd,
   input  logic [ADDR_WIDTH-1:0] addr_rd,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  busy,
   output logic                  err
`ifdef DRAM_RESP_STATS_EN
   ,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count
`endif
);

   // out-of-range latencies are clamped to the legal 1..RD_LATENCY_MAX window
   localparam int PIPE_STAGES = (RD_LATENCY > RD_LATENCY_MAX) ? RD_LATENCY_MAX :
                                (RD_LATENCY < 1) ? 1 : RD_LATENCY;
   localparam logic [31:0] PERIOD_LAST = 32'(REFRESH_PERIOD - 1);
   localparam logic [31:0] WINDOW_LAST = 32'((REFRESH_CYCLES < 1) ? 0 : REFRESH_CYCLES - 1);

   state_t                state, state_nxt;
   logic [31:0]           cnt, cnt_nxt;
   logic                  wr_ok, rd_ok;
   logic [MEM_AW-1:0]     wa, ra;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  pipe_vld;
   logic [DATA_WIDTH-1:0] pipe_data;
   logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

   // upper address bits alias onto the store and are deliberately ignored
   logic unused_addr_bits;
   assign unused_addr_bits = ^{addr_wr[ADDR_WIDTH-1:MEM_AW], addr_rd[ADDR_WIDTH-1:MEM_AW]};

   assign busy  = (state == REFRESH);
   assign wr_ok = en_wr & ~busy;
   assign rd_ok = en_rd & ~busy;
   assign wa    = addr_wr[MEM_AW-1:0];
   assign ra    = addr_rd[MEM_AW-1:0];

   // write-first bypass so a same-edge write is seen by the read
   assign rd_data = (wr_ok && (wa == ra)) ? data_in : mem[ra];

   // backing store; contents survive reset
   always_ff @(posedge clk) begin
      if (wr_ok) mem[wa] <= data_in;
   end

   // state and refresh counter registers
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= ACTIVE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // one counter times both the active span and the refresh window
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ACTIVE: begin
            if (REFRESH_PERIOD != 0) begin
               if (cnt == PERIOD_LAST) begin
                  state_nxt = REFRESH;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 32'd1;
               end
            end
         end
         REFRESH: begin
            if (cnt == WINDOW_LAST) begin
               state_nxt = ACTIVE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 32'd1;
            end
         end
         default: begin
            state_nxt = ACTIVE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // sticky error on any request that lands in a refresh window
   always_ff @(posedge clk or posedge arst) begin
      if (arst)                     err <= 1'b0;
      else if ((en_wr | en_rd) & busy) err <= 1'b1;
   end

   dram_resp_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (PIPE_STAGES)
   ) u_rd_pipe (
      .clk      (clk),
      .arst     (arst),
      .in_vld   (rd_ok),
      .in_data  (rd_data),
      .out_vld  (pipe_vld),
      .out_data (pipe_data)
   );

   // output register: one-cycle valid pulse, data held between reads
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         valid    <= 1'b0;
         data_out <= '0;
      end else begin
         valid <= pipe_vld;
         if (pipe_vld) data_out <= pipe_data;
      end
   end

`ifdef DRAM_RESP_STATS_EN
   // accepted-request counters, wrapping naturally
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (rd_ok) rd_count <= rd_count + 32'd1;
         if (wr_ok) wr_count <= wr_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dram_resp.sv
// Scoreboard bench for dram_resp: stimulus pushes expected reads, a negedge
// monitor pops and compares whenever valid is seen.
module tb_dram_resp;

   localparam int DW  = 32;
   localparam int AW  = 18;
   localparam int MAW = 12;
   localparam int LAT = 4;
   localparam int RP  = 16;
   localparam int RC  = 3;
   localparam int BIG = 1 << 30;

   logic          clk     = 1'b0;
   logic          arst    = 1'b1;
   logic          en_wr   = 1'b0;
   logic          en_rd   = 1'b0;
   logic [AW-1:0] addr_wr = '0;
   logic [AW-1:0] addr_rd = '0;
   logic [DW-1:0] data_in = '0;
   logic          valid, busy, err;
   logic [DW-1:0] data_out;
`ifdef DRAM_RESP_STATS_EN
   logic [31:0]   rd_count, wr_count;
`endif

   typedef struct {
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   logic [DW-1:0] mem_m [0:(1<<MAW)-1];
   int            cyc      = 0;
   int            err_from = BIG;
   int            checks   = 0;
   int            errors   = 0;

   dram_resp #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .MEM_AW         (MAW),
      .RD_LATENCY     (LAT),
      .REFRESH_PERIOD (RP),
      .REFRESH_CYCLES (RC)
   ) dut (
      .clk      (clk),
      .arst     (arst),
      .en_wr    (en_wr),
      .addr_wr  (addr_wr),
      .data_in  (data_in),
      .en_rd    (en_rd),
      .addr_rd  (addr_rd),
      .valid    (valid),
      .data_out (data_out),
      .busy     (busy),
      .err      (err)
`ifdef DRAM_RESP_STATS_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   always #5 clk = ~clk;

   // edges since reset release
   always @(posedge clk or posedge arst) begin
      if (arst) cyc <= 0;
      else      cyc <= cyc + 1;
   end

   // refresh schedule: busy after edge e when e falls in the last RC slots of each RP+RC period
   function automatic bit exp_busy(int e);
      return (e % (RP + RC)) >= RP;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // monitor
   always @(negedge clk) begin
      if (arst) begin
         chk("rst_valid", 32'(valid), 32'd0);
         chk("rst_data", data_out, 32'd0);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_err", 32'(err), 32'd0);
      end else begin
         chk("busy", 32'(busy), 32'(exp_busy(cyc)));
         chk("err", 32'(err), 32'(cyc >= err_from));
         if (valid) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got valid data 0x%0h, want no valid (cycle %0d)", data_out, cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rd_data", data_out, e.data);
               chk("rd_latency", cyc, e.due);
            end
         end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_valid: got no valid, want data 0x%0h at cycle %0d", e.data, e.due);
         end
      end
   end

   // one request cycle, issued at a negedge and sampled at the next posedge
   task automatic req(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic rd, input logic [AW-1:0] ra);
      bit   ok;
      exp_t e;
      ok      = !exp_busy(cyc);
      en_wr   = wr;
      addr_wr = wa;
      data_in = wd;
      en_rd   = rd;
      addr_rd = ra;
      if (!ok && (wr || rd) && err_from > cyc + 1) err_from = cyc + 1;
      if (ok && wr) mem_m[wa[MAW-1:0]] = wd;
      if (ok && rd) begin
         e.data = mem_m[ra[MAW-1:0]];
         e.due  = cyc + 1 + LAT;
         sb.push_back(e);
      end
      @(negedge clk);
      en_wr = 1'b0;
      en_rd = 1'b0;
   endtask

   task automatic idle_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   // wait until the next n sampling edges are all outside a refresh window
   task automatic wait_free(input int n);
      bit hit;
      do begin
         hit = 1'b0;
         for (int j = 0; j < n; j++) if (exp_busy(cyc + j)) hit = 1'b1;
         if (hit) @(negedge clk);
      end while (hit);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // reset
      repeat (3) @(negedge clk);
      #2 arst = 1'b0;
      @(negedge clk);

      // refresh window: read at edge 15 survives, requests at 17/18 dropped
      req(1'b1, 18'h00020, 32'hA5A5_0001, 1'b0, '0);
      idle_until(14);
      req(1'b0, '0, '0, 1'b1, 18'h00020);
      idle_until(16);
      req(1'b0, '0, '0, 1'b1, 18'h00020);
      req(1'b1, 18'h00020, 32'h0000_0BAD, 1'b0, '0);

      // basic write/read, plus dropped write left store untouched
      wait_free(3);
      req(1'b1, 18'h00010, 32'hDEAD_BEEF, 1'b0, '0);
      req(1'b0, '0, '0, 1'b1, 18'h00010);
      req(1'b0, '0, '0, 1'b1, 18'h00020);

      // streaming
      wait_free(8);
      for (int i = 0; i < 8; i++) req(1'b1, 18'(i), 32'(i + 1), 1'b0, '0);
      wait_free(8);
      for (int i = 0; i < 8; i++) req(1'b0, '0, '0, 1'b1, 18'(i));

      // same-edge hazard
      wait_free(2);
      req(1'b1, 18'h00003, 32'h0000_0055, 1'b1, 18'h00003);
      req(1'b1, 18'h00003, 32'h0000_0077, 1'b1, 18'h00004);

      // aliasing
      wait_free(3);
      req(1'b1, 18'h01005, 32'h0000_0011, 1'b0, '0);
      req(1'b0, '0, '0, 1'b1, 18'h00005);
      req(1'b0, '0, '0, 1'b1, 18'h3F005);

      // reset two cycles after a read: it must never return
      repeat (8) @(negedge clk);
      wait_free(3);
      req(1'b0, '0, '0, 1'b1, 18'h00010);
      @(negedge clk);
      #2 arst = 1'b1;
      sb.delete();
      err_from = BIG;
      repeat (3) @(negedge clk);
      #2 arst = 1'b0;
      @(negedge clk);

      // store survives reset
      wait_free(3);
      req(1'b0, '0, '0, 1'b1, 18'h00010);
      req(1'b0, '0, '0, 1'b1, 18'h00003);
      req(1'b0, '0, '0, 1'b1, 18'h00005);

      // drain
      for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d reads outstanding, want 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
